// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
//   state_t    : controller states (IDLE, SHIFT, DONE)
//   cnt_width  : width of the bit counter needed to index WIDTH bits
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // At least one bit so the counter stays a legal vector for tiny widths.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
// Purely combinational one-bit full adder, reused every cycle by serial_adder.
// Ports:
//   a, b  : operand bits
//   c_p   : carry in from the previous bit position
//   s     : sum bit
//   c_n   : carry out to the next bit position
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_p,
    output logic s,
    output logic c_n
);

    assign s   = a ^ b ^ c_p;
    assign c_n = (a & b) | (a & c_p) | (b & c_p);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on an
// accepted start, then adds them LSB-first, one bit per clock, through a
// single fa_cell. The result appears with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed
// overflow output 'ovf'.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   start    : request an addition, sampled only when idle
//   a, b     : operands, captured on accepted start
//   cin      : carry-in, captured on accepted start
//   busy     : high while bits are being processed
//   done     : one-cycle pulse, sum/cout valid from this cycle
//   sum      : result (shifts during an addition, then held)
//   cout     : final carry-out, held with sum
//   ovf      : (SERIAL_ADDER_OVF_EN only) two's-complement overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_next;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .c_p (carry),
        .s   (s_bit),
        .c_n (c_next)
    );

    // The sum register doubles as the result shift register: after WIDTH
    // shifts every stale bit has been pushed out. cout (and ovf) are
    // registered on the same edge as the last sum bit so both are valid
    // during the done cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry register holds the carry into the MSB here
                        ovf   <= carry ^ c_next;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8). Expected results come from
// plain integer arithmetic on the operands. Define SERIAL_ADDER_OVF_EN for
// both files to also check the ovf output.
module tb_serial_adder;

    localparam int W = 8;

    logic         CLOCK_50;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands with start high, pass the accepting edge, land 1ns into
    // the first busy cycle.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vcin, input bit hold_start);
        a     = va;
        b     = vb;
        cin   = vcin;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        if (!hold_start) start = 1'b0;
    endtask

    // Called 1ns into cycle 1 after the accepting edge. Waits (bounded) for
    // done, checking latency, busy length and the result against a+b+cin.
    // Returns 1ns into the done cycle.
    task automatic finishAdd(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic ecin, input bit change_ops);
        int lat;
        int busy_cnt;
        int total;
        int s_total;
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat <= W + 4) begin
            if (busy === 1'b1) busy_cnt++;
            if (change_ops && lat == 3) begin
                a = 8'hFF;
                b = 8'hFF;
            end
            @(posedge CLOCK_50);
            #1;
            lat++;
        end
        total = int'(ea) + int'(eb) + int'(ecin);
        checkOutput({tag, "_latency"}, lat, W + 1);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, W);
        checkOutput({tag, "_busy_in_done"}, busy, 1'b0);
        checkOutput({tag, "_sum"}, sum, total % 256);
        checkOutput({tag, "_cout"}, cout, (total >= 256) ? 1 : 0);
`ifdef SERIAL_ADDER_OVF_EN
        s_total = int'($signed(ea)) + int'($signed(eb)) + int'(ecin);
        checkOutput({tag, "_ovf"}, ovf, (s_total > 127 || s_total < -128) ? 1 : 0);
`else
        s_total = 0;
`endif
    endtask

    task automatic runAdd(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vcin);
        applyStimulus(va, vb, vcin, 1'b0);
        finishAdd(tag, va, vb, vcin, 1'b0);
        @(posedge CLOCK_50);
        #1;
        checkOutput({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int done_seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", cout, 1'b0);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;

        runAdd("add_0f_01", 8'h0F, 8'h01, 1'b0);
        runAdd("add_ff_01", 8'hFF, 8'h01, 1'b0);
        runAdd("add_7f_00_c1", 8'h7F, 8'h00, 1'b1);

        // Start held high, operands changed mid-addition.
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b1);
        finishAdd("held", 8'h12, 8'h34, 1'b0, 1'b1);
        @(posedge CLOCK_50);
        #1;
        checkOutput("held_idle_busy", busy, 1'b0);
        checkOutput("held_idle_done", done, 1'b0);
        @(posedge CLOCK_50);
        #1;
        checkOutput("held_restart_busy", busy, 1'b1);
        start = 1'b0;
        finishAdd("held_second", 8'hFF, 8'hFF, 1'b0, 1'b0);
        @(posedge CLOCK_50);
        #1;

        // Reset in the 4th busy cycle discards the addition.
        applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("mid_busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_busy", busy, 1'b0);
        checkOutput("mid_reset_done", done, 1'b0);
        checkOutput("mid_reset_sum", sum, 0);
        checkOutput("mid_reset_cout", cout, 1'b0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (W + 4) begin
            @(posedge CLOCK_50);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checkOutput("mid_reset_no_activity", done_seen, 0);
        runAdd("after_reset", 8'h01, 8'h01, 1'b0);

        // Randomised sweep.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            runAdd("rand", ra, rb, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
